top: RTL and testbench
======================

# top

Debug-configurable Zigbee-style baseband chain wrapper. System path: 4-bit input FIFO → bit coder (I/Q) → CORDIC phase/magnitude → clock/data recovery (CDR) → 1-bit output FIFO, plus a side decoder. DEMUX selects let external pins drive any sub-block input, and MUX selects expose any sub-block output, so each block can be tested stand-alone.

## Interface
- Parameters: none. FIFO depths are fixed: inFIFO 8×4 bits, outFIFO 8×1 bit.
- inClock  in  1  sole clock, rising edge
- inReset  in  1  asynchronous, active-high reset; clears every register
- in_inFIFO_inData  in  4  inFIFO write word
- in_outFIFO_inReadEnable  in  1  outFIFO pop
- in_DEMUX_inDEMUX1 / in_DEMUX_inDEMUX2  in  1 each  external 1-bit stimuli, routed by SEL1 / SEL2
- in_DEMUX_inDEMUX17 / in_DEMUX_inDEMUX18  in  4 each  external I / Q, routed by SEL17
- in_DEMUX_inSEL1, in_DEMUX_inSEL2  in  3 each  DEMUX1 / DEMUX2 destination
- in_MUX_inSEL3  in  1  0 = system view, 1 = debug view
- in_MUX_inSEL6, in_MUX_inSEL9, in_MUX_inSEL15  in  2 each; in_MUX_inSEL11, in_MUX_inSEL12  in  1 each  output selects
- in_DEMUX_inSEL17  in  1  0: DEMUX17/18 → decoder I/Q (CORDIC takes coder I/Q); 1: → CORDIC I/Q (decoder takes coder I/Q)
- out_MUX_outMUX9, out_MUX_outMUX10  out  4 each; out_MUX_outMUX15, out_MUX_outMUX16  out  1 each

## Operation
- **Input routing.** A selected block input takes the DEMUX pin; an unselected input takes its internal source (shown in brackets).
  - SEL1: 000 decoder EOC [coder valid]; 001 coder data [inFIFO bit]; 010 inFIFO RE [coder RE]; 011 CDR enable [CORDIC done]; 100 outFIFO WE [CDR valid]; 101–111 none.
  - SEL2: 000 inFIFO WE [0]; 001 coder empty [inFIFO empty]; 010 CORDIC enable [coder valid]; 011 CDR DIR [CORDIC DIR]; 100 outFIFO data [CDR data]; 101–111 none.
- **inFIFO.** Each cycle with WE=1 and not full pushes in_inFIFO_inData; writes while full are dropped.
  - Serial read, LSB first: serial bit = head[b], where b is a 2-bit index.
  - RE with not empty increments b; the read at b=3 pops the word and wraps b to 0.
  - empty ⇔ count==0. Push and pop in the same cycle are both performed.
- **Coder.** RE = !empty (combinational). On a clock edge with !empty:
  - I ← data ? 4'b0111 : 4'b1001.
  - Q ← old I.
  - valid ← 1.
  - Otherwise valid ← 0 and I/Q hold.
- **Decoder.** Each clock: valid ← EOC. When EOC=1, data ← ~I[3].
- **CORDIC.** FSM IDLE → RUN(4 cycles) → DONE(1 cycle) → IDLE; enable is sampled only in IDLE.
  - Capture: sign-extend I/Q to 8-bit x/y; z=0. If x<0: x=−x, y=−y, z=128.
  - Iterations i=0..3, all on old values, arithmetic shifts:
    - y≥0: x+=y>>>i, y−=x>>>i, z+=A[i].
    - else: x−=y>>>i, y+=x>>>i, z−=A[i].
    - A = {32,19,10,5}; z is 8-bit and wraps.
  - In DONE, register:
    - phase = ((z+8)>>4) mod 16.
    - mag = min(x,15), gain not compensated.
    - DIR = 1 iff (phase − prevPhase) mod 16 ∈ 1..7; then prevPhase ← phase.
  - done is high for the one DONE cycle.
- **CDR.** Each cycle with enable=1 shifts DIR into a 3-bit history and increments a mod-3 counter; enable=0 holds both. The cycle after the third sample: valid=1 and data=majority(history); otherwise valid=0.
- **outFIFO.** WE with not full pushes the data bit. outData = head bit (show-ahead; 0 when empty). ReadEnable with not empty pops. outEmpty ⇔ count==0.
- **Output muxes** (combinational from registers).
  - SEL3=0: outMUX9 = coder I, outMUX10 = coder Q, outMUX15 = outFIFO data, outMUX16 = outFIFO empty.
  - SEL3=1:
    - SEL9: 00 coder I, 01 inFIFO head word, 10 CORDIC mag, 11 outFIFO count.
    - SEL6: 00 coder Q, 01 inFIFO count, 10 CORDIC phase, 11 {0, CDR history}.
    - SEL15 → (outMUX15, outMUX16):
      - 00 (inFIFO bit, inFIFO empty).
      - 01 with SEL11=0: (coder valid, coder RE); with SEL11=1: (decoder data, decoder valid).
      - 10 (CORDIC done, CORDIC DIR).
      - 11 with SEL12=0: (CDR data, CDR valid); with SEL12=1: (outFIFO data, outFIFO empty).

## Timing
- Reset clears all registers; both FIFOs are empty and the CORDIC is in IDLE.
- Output values under reset:
  - SEL3=0: outMUX9=0, outMUX10=0, outMUX15=0, outMUX16=1.
  - SEL3=1: every mux choice reads 0, except the empty flags (1) and coder RE, which is 0 with the internal source and otherwise follows the inverted coder-empty input.
- Reset mid-operation aborts the CORDIC and flushes both FIFOs.
- Latencies:
  - Coder: 1 cycle.
  - Decoder: 1 cycle.
  - CORDIC: enable sampled at edge N → done high between edges N+5 and N+6.
  - CDR: valid 1 cycle after the third sample.

## Test plan
- inFIFO (SEL1=010, SEL2=000, SEL3=1, SEL15=00, SEL9=01): WE=1 for 3 cycles with data 0001 → count 3, head 0001. Then RE=1 → outMUX15 serial 1,0,0,0, and count drops to 2 after the 4th read.
- Coder (SEL1=001, SEL2=001, SEL15=01, SEL11=0): empty=0, data=1 → next cycle I=0111, valid=1; then data=0 → I=1001, Q=0111.
- Decoder (SEL17=0, SEL1=000, SEL15=01, SEL11=1): EOC=1 with I=1010 → data=0, valid=1; I=0010 → data=1.
- CORDIC (SEL17=1, SEL2=010, SEL6=10, SEL9=10): I=1101, Q=1100, enable pulse → 5 cycles later done=1, phase=10, mag=9.
- CDR (SEL1=011, SEL2=011, SEL15=11, SEL12=0): enable=1, DIR=0 for 6 cycles → two valid pulses with data 0. Then DIR=1 for 3 samples → valid with data 1.
- System mode: write 4'b0110 → outFIFO eventually non-empty (outMUX16→0); ReadEnable drains it back to empty.

Source files
------------

// File: rtl/top.sv
// Zigbee-style baseband test wrapper: inFIFO -> bit coder -> CORDIC -> CDR -> outFIFO,
// plus a side decoder. DEMUX pins can drive any block input; MUX selects expose any block output.
module top (
   input  logic       inClock,
   input  logic       inReset,
   input  logic [3:0] in_inFIFO_inData,
   input  logic       in_outFIFO_inReadEnable,
   input  logic       in_DEMUX_inDEMUX1,
   input  logic       in_DEMUX_inDEMUX2,
   input  logic [3:0] in_DEMUX_inDEMUX17,
   input  logic [3:0] in_DEMUX_inDEMUX18,
   input  logic [2:0] in_DEMUX_inSEL1,
   input  logic [2:0] in_DEMUX_inSEL2,
   input  logic       in_MUX_inSEL3,
   input  logic [1:0] in_MUX_inSEL6,
   input  logic [1:0] in_MUX_inSEL9,
   input  logic [1:0] in_MUX_inSEL15,
   input  logic       in_MUX_inSEL11,
   input  logic       in_MUX_inSEL12,
   input  logic       in_DEMUX_inSEL17,
   output logic [3:0] out_MUX_outMUX9,
   output logic [3:0] out_MUX_outMUX10,
   output logic       out_MUX_outMUX15,
   output logic       out_MUX_outMUX16
);
   typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

   logic decEoc, coderData, inRe, cdrEn, outWe;
   logic inWe, coderEmpty, cordicEn, cdrDir, outDataIn, decIMsb;
   logic [3:0] cordicI, cordicQ;

   logic [3:0] inMem [8];
   logic [2:0] inWrPtr, inRdPtr;
   logic [3:0] inCount, inHead;
   logic [1:0] inBitIdx;
   logic inEmpty, inFull, inBit, inPush, inReadBit, inPop;

   logic coderRe, coderValid;
   logic [3:0] coderI, coderQ;
   logic decValid, decData;

   stateT state;
   logic signed [7:0] x, y, xSh, ySh, xIn, yIn;
   logic [7:0] z, angle, zRound;
   logic [1:0] iter;
   logic [3:0] phase, mag, prevPhase, nextPhase, phaseDiff;
   logic cordicDir, cordicDone;

   logic [2:0] cdrHist, cdrHistNext;
   logic [1:0] cdrCnt;
   logic cdrValid, cdrData;

   logic [7:0] outMem;
   logic [2:0] outWrPtr, outRdPtr;
   logic [3:0] outCount;
   logic outEmpty, outFull, outHead, outPush, outPop;

   // Debug pins override the internal source only when selected
   assign decEoc     = (in_DEMUX_inSEL1 == 3'd0) ? in_DEMUX_inDEMUX1 : coderValid;
   assign coderData  = (in_DEMUX_inSEL1 == 3'd1) ? in_DEMUX_inDEMUX1 : inBit;
   assign inRe       = (in_DEMUX_inSEL1 == 3'd2) ? in_DEMUX_inDEMUX1 : coderRe;
   assign cdrEn      = (in_DEMUX_inSEL1 == 3'd3) ? in_DEMUX_inDEMUX1 : cordicDone;
   assign outWe      = (in_DEMUX_inSEL1 == 3'd4) ? in_DEMUX_inDEMUX1 : cdrValid;
   assign inWe       = (in_DEMUX_inSEL2 == 3'd0) ? in_DEMUX_inDEMUX2 : 1'b0;
   assign coderEmpty = (in_DEMUX_inSEL2 == 3'd1) ? in_DEMUX_inDEMUX2 : inEmpty;
   assign cordicEn   = (in_DEMUX_inSEL2 == 3'd2) ? in_DEMUX_inDEMUX2 : coderValid;
   assign cdrDir     = (in_DEMUX_inSEL2 == 3'd3) ? in_DEMUX_inDEMUX2 : cordicDir;
   assign outDataIn  = (in_DEMUX_inSEL2 == 3'd4) ? in_DEMUX_inDEMUX2 : cdrData;
   assign decIMsb    = in_DEMUX_inSEL17 ? coderI[3] : in_DEMUX_inDEMUX17[3];
   assign cordicI    = in_DEMUX_inSEL17 ? in_DEMUX_inDEMUX17 : coderI;
   assign cordicQ    = in_DEMUX_inSEL17 ? in_DEMUX_inDEMUX18 : coderQ;

   assign inHead    = inMem[inRdPtr];
   assign inEmpty   = inCount == 4'd0;
   assign inFull    = inCount == 4'd8;
   assign inBit     = inHead[inBitIdx];
   assign inPush    = inWe && !inFull;
   assign inReadBit = inRe && !inEmpty;
   assign inPop     = inReadBit && (inBitIdx == 2'd3);

   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         for (int k = 0; k < 8; k++) inMem[k] <= '0;
         inWrPtr  <= '0;
         inRdPtr  <= '0;
         inCount  <= '0;
         inBitIdx <= '0;
      end else begin
         if (inPush) begin
            inMem[inWrPtr] <= in_inFIFO_inData;
            inWrPtr        <= inWrPtr + 3'd1;
         end
         if (inReadBit) inBitIdx <= inBitIdx + 2'd1;
         if (inPop) inRdPtr <= inRdPtr + 3'd1;
         inCount <= inCount + {3'd0, inPush} - {3'd0, inPop};
      end
   end

   assign coderRe = !coderEmpty;

   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         coderI     <= '0;
         coderQ     <= '0;
         coderValid <= 1'b0;
         decValid   <= 1'b0;
         decData    <= 1'b0;
      end else begin
         coderValid <= !coderEmpty;
         if (!coderEmpty) begin
            coderI <= coderData ? 4'b0111 : 4'b1001;
            coderQ <= coderI;
         end
         decValid <= decEoc;
         if (decEoc) decData <= ~decIMsb;
      end
   end

   assign xIn       = {{4{cordicI[3]}}, cordicI};
   assign yIn       = {{4{cordicQ[3]}}, cordicQ};
   assign xSh       = x >>> iter;
   assign ySh       = y >>> iter;
   assign zRound    = z + 8'd8;
   assign nextPhase = zRound[7:4];
   assign phaseDiff = nextPhase - prevPhase;

   always_comb begin
      angle = 8'd32;
      case (iter)
         2'd0: angle = 8'd32;
         2'd1: angle = 8'd19;
         2'd2: angle = 8'd10;
         2'd3: angle = 8'd5;
         default: angle = 8'd32;
      endcase
   end

   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         state      <= StIdle;
         x          <= '0;
         y          <= '0;
         z          <= '0;
         iter       <= '0;
         phase      <= '0;
         mag        <= '0;
         prevPhase  <= '0;
         cordicDir  <= 1'b0;
         cordicDone <= 1'b0;
      end else begin
         cordicDone <= 1'b0;
         case (state)
            StIdle: if (cordicEn) begin
               // Fold the left half-plane over so the rotations always converge
               if (xIn[7]) begin
                  x <= -xIn;
                  y <= -yIn;
                  z <= 8'd128;
               end else begin
                  x <= xIn;
                  y <= yIn;
                  z <= 8'd0;
               end
               iter  <= 2'd0;
               state <= StRun;
            end
            StRun: begin
               if (!y[7]) begin
                  x <= x + ySh;
                  y <= y - xSh;
                  z <= z + angle;
               end else begin
                  x <= x - ySh;
                  y <= y + xSh;
                  z <= z - angle;
               end
               iter <= iter + 2'd1;
               if (iter == 2'd3) state <= StDone;
            end
            StDone: begin
               phase      <= nextPhase;
               mag        <= (x > 8'sd15) ? 4'd15 : x[3:0];
               cordicDir  <= (phaseDiff != 4'd0) && !phaseDiff[3];
               prevPhase  <= nextPhase;
               cordicDone <= 1'b1;
               state      <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign cdrHistNext = {cdrHist[1:0], cdrDir};

   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         cdrHist  <= '0;
         cdrCnt   <= '0;
         cdrValid <= 1'b0;
         cdrData  <= 1'b0;
      end else begin
         cdrValid <= 1'b0;
         if (cdrEn) begin
            cdrHist <= cdrHistNext;
            cdrCnt  <= (cdrCnt == 2'd2) ? 2'd0 : cdrCnt + 2'd1;
            if (cdrCnt == 2'd2) begin
               cdrValid <= 1'b1;
               cdrData  <= (cdrHistNext[0] & cdrHistNext[1]) | (cdrHistNext[1] & cdrHistNext[2])
                         | (cdrHistNext[0] & cdrHistNext[2]);
            end
         end
      end
   end

   assign outEmpty = outCount == 4'd0;
   assign outFull  = outCount == 4'd8;
   assign outHead  = outEmpty ? 1'b0 : outMem[outRdPtr];
   assign outPush  = outWe && !outFull;
   assign outPop   = in_outFIFO_inReadEnable && !outEmpty;

   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         outMem   <= '0;
         outWrPtr <= '0;
         outRdPtr <= '0;
         outCount <= '0;
      end else begin
         if (outPush) begin
            outMem[outWrPtr] <= outDataIn;
            outWrPtr         <= outWrPtr + 3'd1;
         end
         if (outPop) outRdPtr <= outRdPtr + 3'd1;
         outCount <= outCount + {3'd0, outPush} - {3'd0, outPop};
      end
   end

   always_comb begin
      out_MUX_outMUX9  = coderI;
      out_MUX_outMUX10 = coderQ;
      out_MUX_outMUX15 = outHead;
      out_MUX_outMUX16 = outEmpty;
      if (in_MUX_inSEL3) begin
         case (in_MUX_inSEL9)
            2'd0: out_MUX_outMUX9 = coderI;
            2'd1: out_MUX_outMUX9 = inHead;
            2'd2: out_MUX_outMUX9 = mag;
            default: out_MUX_outMUX9 = outCount;
         endcase
         case (in_MUX_inSEL6)
            2'd0: out_MUX_outMUX10 = coderQ;
            2'd1: out_MUX_outMUX10 = inCount;
            2'd2: out_MUX_outMUX10 = phase;
            default: out_MUX_outMUX10 = {1'b0, cdrHist};
         endcase
         case (in_MUX_inSEL15)
            2'd0: {out_MUX_outMUX15, out_MUX_outMUX16} = {inBit, inEmpty};
            2'd1: {out_MUX_outMUX15, out_MUX_outMUX16} =
               in_MUX_inSEL11 ? {decData, decValid} : {coderValid, coderRe};
            2'd2: {out_MUX_outMUX15, out_MUX_outMUX16} = {cordicDone, cordicDir};
            default: {out_MUX_outMUX15, out_MUX_outMUX16} =
               in_MUX_inSEL12 ? {outHead, outEmpty} : {cdrData, cdrValid};
         endcase
      end
   end
endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the baseband test wrapper.
module tb_top;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fifoData;
   logic       readEn;
   logic       d1, d2;
   logic [3:0] d17, d18;
   logic [2:0] sel1, sel2;
   logic       sel3, sel11, sel12, sel17;
   logic [1:0] sel6, sel9, sel15;
   logic [3:0] mux9, mux10;
   logic       mux15, mux16;
   int         checks = 0;
   int         failures = 0;
   int         waited;
   logic       seen;

   top dut (
      .inClock(clk),
      .inReset(rst),
      .in_inFIFO_inData(fifoData),
      .in_outFIFO_inReadEnable(readEn),
      .in_DEMUX_inDEMUX1(d1),
      .in_DEMUX_inDEMUX2(d2),
      .in_DEMUX_inDEMUX17(d17),
      .in_DEMUX_inDEMUX18(d18),
      .in_DEMUX_inSEL1(sel1),
      .in_DEMUX_inSEL2(sel2),
      .in_MUX_inSEL3(sel3),
      .in_MUX_inSEL6(sel6),
      .in_MUX_inSEL9(sel9),
      .in_MUX_inSEL15(sel15),
      .in_MUX_inSEL11(sel11),
      .in_MUX_inSEL12(sel12),
      .in_DEMUX_inSEL17(sel17),
      .out_MUX_outMUX9(mux9),
      .out_MUX_outMUX10(mux10),
      .out_MUX_outMUX15(mux15),
      .out_MUX_outMUX16(mux16)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; fifoData = 4'd0; readEn = 1'b0; d1 = 1'b0; d2 = 1'b0;
      d17 = 4'd0; d18 = 4'd0; sel1 = 3'b101; sel2 = 3'b101; sel3 = 1'b0;
      sel6 = 2'd0; sel9 = 2'd0; sel15 = 2'd0; sel11 = 1'b0; sel12 = 1'b0; sel17 = 1'b0;

      // Output values under reset
      #1;
      check4("rst_mux9", mux9, 4'd0);
      check4("rst_mux10", mux10, 4'd0);
      check1("rst_mux15", mux15, 1'b0);
      check1("rst_mux16", mux16, 1'b1);
      sel3 = 1'b1; sel9 = 2'd3; sel6 = 2'd3; sel15 = 2'd0; #1;
      check4("rst_outcount", mux9, 4'd0);
      check1("rst_in_empty", mux16, 1'b1);
      sel15 = 2'd1; #1;
      check1("rst_coder_re_int", mux16, 1'b0);
      sel2 = 3'b001; d2 = 1'b0; #1;
      check1("rst_coder_re_ext", mux16, 1'b1);
      sel15 = 2'd3; sel12 = 1'b1; #1;
      check1("rst_out_empty", mux16, 1'b1);

      // inFIFO: three writes, then serial read LSB first
      sel1 = 3'b010; sel2 = 3'b000; sel15 = 2'd0; sel9 = 2'd1; sel6 = 2'd1;
      fifoData = 4'b0001; d1 = 1'b0; d2 = 1'b1;
      doReset();
      tick(); tick(); tick();
      d2 = 1'b0;
      check4("in_count3", mux10, 4'd3);
      check4("in_head", mux9, 4'b0001);
      check1("in_bit0", mux15, 1'b1);
      check1("in_not_empty", mux16, 1'b0);
      d1 = 1'b1;
      tick(); check1("in_bit1", mux15, 1'b0); check4("in_count_b1", mux10, 4'd3);
      tick(); check1("in_bit2", mux15, 1'b0);
      tick(); check1("in_bit3", mux15, 1'b0);
      tick(); check4("in_count2", mux10, 4'd2); check1("in_next_bit0", mux15, 1'b1);
      d1 = 1'b0;

      // Coder
      sel1 = 3'b001; sel2 = 3'b001; sel15 = 2'd1; sel11 = 1'b0; sel9 = 2'd0; sel6 = 2'd0;
      d2 = 1'b1;
      doReset();
      d1 = 1'b1; d2 = 1'b0; #1;
      check1("coder_re", mux16, 1'b1);
      tick();
      check4("coder_i1", mux9, 4'b0111);
      check4("coder_q1", mux10, 4'b0000);
      check1("coder_valid1", mux15, 1'b1);
      d1 = 1'b0; tick();
      check4("coder_i0", mux9, 4'b1001);
      check4("coder_q0", mux10, 4'b0111);
      d2 = 1'b1; #1;
      check1("coder_re_off", mux16, 1'b0);
      tick();
      check1("coder_valid_off", mux15, 1'b0);
      check4("coder_i_hold", mux9, 4'b1001);

      // Decoder
      sel1 = 3'b000; sel2 = 3'b101; sel17 = 1'b0; sel15 = 2'd1; sel11 = 1'b1;
      doReset();
      d17 = 4'b1010; d1 = 1'b1; tick();
      check1("dec_data0", mux15, 1'b0);
      check1("dec_valid", mux16, 1'b1);
      d17 = 4'b0010; tick();
      check1("dec_data1", mux15, 1'b1);
      d1 = 1'b0; tick();
      check1("dec_valid_off", mux16, 1'b0);
      check1("dec_data_hold", mux15, 1'b1);

      // CORDIC: (-3,-4) then (4,1)
      sel1 = 3'b101; sel2 = 3'b010; sel17 = 1'b1; sel6 = 2'd2; sel9 = 2'd2; sel15 = 2'd2;
      d2 = 1'b0;
      doReset();
      d17 = 4'b1101; d18 = 4'b1100; d2 = 1'b1; tick(); d2 = 1'b0;
      tick(); tick(); tick(); tick();
      check1("cordic_done_early", mux15, 1'b0);
      tick();
      check1("cordic_done", mux15, 1'b1);
      check4("cordic_phase10", mux10, 4'd10);
      check4("cordic_mag9", mux9, 4'd9);
      check1("cordic_dir0", mux16, 1'b0);
      tick();
      check1("cordic_done_pulse", mux15, 1'b0);
      d17 = 4'b0100; d18 = 4'b0001; d2 = 1'b1; tick(); d2 = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      check1("cordic_done2", mux15, 1'b1);
      check4("cordic_phase1", mux10, 4'd1);
      check4("cordic_mag8", mux9, 4'd8);
      check1("cordic_dir1", mux16, 1'b1);

      // CDR
      sel1 = 3'b011; sel2 = 3'b011; sel15 = 2'd3; sel12 = 1'b0; sel6 = 2'd3;
      d1 = 1'b0; d2 = 1'b0;
      doReset();
      d1 = 1'b1;
      tick(); check1("cdr_v1", mux16, 1'b0);
      tick(); check1("cdr_v2", mux16, 1'b0);
      tick(); check1("cdr_v3", mux16, 1'b1); check1("cdr_d3", mux15, 1'b0);
      tick(); check1("cdr_v4", mux16, 1'b0);
      tick(); tick(); check1("cdr_v6", mux16, 1'b1); check1("cdr_d6", mux15, 1'b0);
      d2 = 1'b1;
      tick(); check1("cdr_v7", mux16, 1'b0);
      tick(); tick();
      check1("cdr_v9", mux16, 1'b1);
      check1("cdr_d9", mux15, 1'b1);
      check4("cdr_hist", mux10, 4'b0111);
      d1 = 1'b0; d2 = 1'b0; tick();
      check1("cdr_v_off", mux16, 1'b0);
      check4("cdr_hist_hold", mux10, 4'b0111);

      // outFIFO stand-alone
      sel1 = 3'b100; sel2 = 3'b100; sel15 = 2'd3; sel12 = 1'b1; sel9 = 2'd3;
      doReset();
      d1 = 1'b1; d2 = 1'b1; tick();
      d2 = 1'b0; tick();
      d1 = 1'b0;
      check4("out_count2", mux9, 4'd2);
      check1("out_head1", mux15, 1'b1);
      check1("out_not_empty", mux16, 1'b0);
      readEn = 1'b1; tick();
      check1("out_head0", mux15, 1'b0);
      check1("out_still_full", mux16, 1'b0);
      tick();
      check1("out_empty", mux16, 1'b1);
      check4("out_count0", mux9, 4'd0);
      readEn = 1'b0;

      // System mode end to end
      sel3 = 1'b0; sel1 = 3'b101; sel2 = 3'b000; sel17 = 1'b0;
      fifoData = 4'b0110; d2 = 1'b1;
      doReset();
      for (int i = 0; i < 8; i++) tick();
      d2 = 1'b0;
      seen = 1'b0;
      waited = 0;
      while (!seen && waited < 300) begin
         tick();
         waited++;
         if (mux16 == 1'b0) seen = 1'b1;
      end
      check1("sys_out_nonempty", seen, 1'b1);
      for (int i = 0; i < 150; i++) tick();
      readEn = 1'b1;
      waited = 0;
      while (mux16 !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      readEn = 1'b0;
      tick(); tick();
      check1("sys_drained", mux16, 1'b1);
      check1("sys_data_empty", mux15, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
